// File: rtl/x16_approx_mul_pkg.sv
// Shared definitions for the recursive approximate multiplier family:
// parameter limits, the lower-part-OR adder (LOA) helper and the 2x2/4x4
// multiplier cells.
package x16_approx_mul_pkg;

    localparam int unsigned N16_MAX = 8;
    localparam int unsigned N8_MAX  = 4;
    localparam int unsigned N4_MAX  = 4;

    localparam int unsigned W_OUT = 32;
    localparam int unsigned W_X8  = 16;

    // Lower-part-OR adder on up to 32 bits.
    // Bits [k-1:0] are x|y; bits [w-1:k] are a true add seeded with the
    // AND of the two operand bits at position k-1. Result is truncated to w.
    function automatic logic [31:0] loa(
        input logic [31:0] x,
        input logic [31:0] y,
        input int unsigned k,
        input int unsigned w
    );
        logic [31:0] wmask;
        logic [31:0] lo_mask;
        logic [31:0] lo_msb;
        logic [31:0] hi_sum;
        logic        cin;
        wmask   = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        lo_mask = (k == 0) ? 32'd0 : ((32'd1 << k) - 32'd1);
        lo_msb  = (k == 0) ? 32'd0 : (32'd1 << (k - 1));
        cin     = |(x & y & lo_msb);
        hi_sum  = (x >> k) + (y >> k) + {31'd0, cin};
        return ((hi_sum << k) | ((x | y) & lo_mask)) & wmask;
    endfunction

    // 2x2 cell; the approximate variant reports 3*3 as 7 (fits in 3 bits).
    function automatic logic [3:0] mul2(
        input logic [1:0] a,
        input logic [1:0] b,
        input logic       approx
    );
        logic [3:0] p;
        p = {2'b00, a} * {2'b00, b};
        if (approx && (a == 2'd3) && (b == 2'd3)) begin
            p = 4'd7;
        end
        return p;
    endfunction

    // 4x4 built from four 2x2 cells summed exactly. The first n4 cells in
    // the order LL, LH (aL*bH), HL (aH*bL), HH use the approximate cell.
    function automatic logic [7:0] x4_mul(
        input logic [3:0]  a,
        input logic [3:0]  b,
        input int unsigned n4
    );
        logic [3:0] ll;
        logic [3:0] lh;
        logic [3:0] hl;
        logic [3:0] hh;
        ll = mul2(a[1:0], b[1:0], n4 > 0);
        lh = mul2(a[1:0], b[3:2], n4 > 1);
        hl = mul2(a[3:2], b[1:0], n4 > 2);
        hh = mul2(a[3:2], b[3:2], n4 > 3);
        return {4'd0, ll} + {2'd0, lh, 2'd0} + {2'd0, hl, 2'd0} + {hh, 4'd0};
    endfunction

endpackage

// File: rtl/x16_approx_mul_x8.sv
// x8_approx_mul: combinational 8x8 approximate multiplier.
// Four 4x4 cells, partial products merged with LOA (k = 2*N8) over 16 bits.
// Ports: a, b - 8-bit unsigned operands; p_c - 16-bit combinational product.
module x8_approx_mul
    import x16_approx_mul_pkg::*;
#(
    parameter int unsigned N8 = 0,
    parameter int unsigned N4 = 0
) (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p_c
);

    localparam int unsigned K8 = 2 * N8;

    if (N8 > N8_MAX) begin : g_bad_n8
        $error("x8_approx_mul: N8 out of range");
    end
    if (N4 > N4_MAX) begin : g_bad_n4
        $error("x8_approx_mul: N4 out of range");
    end

    logic [7:0]  pp_ll;
    logic [7:0]  pp_lh;
    logic [7:0]  pp_hl;
    logic [7:0]  pp_hh;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] f;

    // Partial products and LOA accumulation.
    always_comb begin
        pp_ll = x4_mul(a[3:0], b[3:0], N4);
        pp_lh = x4_mul(a[3:0], b[7:4], N4);
        pp_hl = x4_mul(a[7:4], b[3:0], N4);
        pp_hh = x4_mul(a[7:4], b[7:4], N4);
        s1    = loa({20'd0, pp_lh, 4'd0}, {20'd0, pp_hl, 4'd0}, K8, W_X8);
        s2    = loa(s1, {24'd0, pp_ll}, K8, W_X8);
        f     = loa(s2, {16'd0, pp_hh, 8'd0}, K8, W_X8);
        p_c   = f[15:0];
    end

endmodule

// File: rtl/x16_approx_mul.sv
// x16_approx_mul: 16x16 unsigned approximate multiplier, one-cycle latency.
// Four x8_approx_mul partial products merged by LOA (k = 2*N16), registered.
// Ports: clk - rising-edge clock; reset - async active-low clear;
//        a, b - 16-bit unsigned operands; out - registered 32-bit product.
module x16_approx_mul
    import x16_approx_mul_pkg::*;
#(
    parameter int unsigned N16 = 0,
    parameter int unsigned N8  = 0,
    parameter int unsigned N4  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] out
);

    localparam int unsigned K16 = 2 * N16;

    if (N16 > N16_MAX) begin : g_bad_n16
        $error("x16_approx_mul: N16 out of range");
    end

    logic [15:0] pp_ll;
    logic [15:0] pp_lh;
    logic [15:0] pp_hl;
    logic [15:0] pp_hh;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] f_c;

    x8_approx_mul #(.N8(N8), .N4(N4)) u_ll (.a(a[7:0]),  .b(b[7:0]),  .p_c(pp_ll));
    x8_approx_mul #(.N8(N8), .N4(N4)) u_lh (.a(a[7:0]),  .b(b[15:8]), .p_c(pp_lh));
    x8_approx_mul #(.N8(N8), .N4(N4)) u_hl (.a(a[15:8]), .b(b[7:0]),  .p_c(pp_hl));
    x8_approx_mul #(.N8(N8), .N4(N4)) u_hh (.a(a[15:8]), .b(b[15:8]), .p_c(pp_hh));

    // Accumulation: cross terms first, then the low term, then the high term.
    always_comb begin
        s1  = loa({8'd0, pp_lh, 8'd0}, {8'd0, pp_hl, 8'd0}, K16, W_OUT);
        s2  = loa(s1, {16'd0, pp_ll}, K16, W_OUT);
        f_c = loa(s2, {pp_hh, 16'd0}, K16, W_OUT);
    end

    // Output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out <= '0;
        end else begin
            out <= f_c;
        end
    end

endmodule

// File: tb/tb_x16_approx_mul.sv
module tb_x16_approx_mul;

    logic        clk;
    logic        reset;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] out_ex;
    logic [31:0] out_n16;
    logic [31:0] out_n4;
    logic [31:0] out_mix;

    int n_checks;
    int n_pass;

    x16_approx_mul #(.N16(0), .N8(0), .N4(0)) dut_ex  (.clk(clk), .reset(reset), .a(a), .b(b), .out(out_ex));
    x16_approx_mul #(.N16(8), .N8(0), .N4(0)) dut_n16 (.clk(clk), .reset(reset), .a(a), .b(b), .out(out_n16));
    x16_approx_mul #(.N16(0), .N8(0), .N4(4)) dut_n4  (.clk(clk), .reset(reset), .a(a), .b(b), .out(out_n4));
    x16_approx_mul #(.N16(5), .N8(3), .N4(2)) dut_mix (.clk(clk), .reset(reset), .a(a), .b(b), .out(out_mix));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: arithmetic on integers following the LOA definition.
    function automatic longint m_loa(input longint x, input longint y, input int k, input int w);
        longint p;
        longint lo;
        longint cin;
        longint hi;
        p   = 64'd1 << k;
        lo  = (x | y) % p;
        cin = (k > 0) ? (((x >> (k - 1)) & 1) & ((y >> (k - 1)) & 1)) : 0;
        hi  = x / p + y / p + cin;
        return (hi * p + lo) % (64'd1 << w);
    endfunction

    function automatic longint m_mul2(input longint x, input longint y, input bit approx);
        if (approx && x == 3 && y == 3) return 7;
        return x * y;
    endfunction

    function automatic longint m_mul4(input longint x, input longint y, input int n4);
        longint xl, xh, yl, yh;
        xl = x % 4; xh = x / 4; yl = y % 4; yh = y / 4;
        return m_mul2(xl, yl, n4 > 0) + 4 * m_mul2(xl, yh, n4 > 1)
             + 4 * m_mul2(xh, yl, n4 > 2) + 16 * m_mul2(xh, yh, n4 > 3);
    endfunction

    function automatic longint m_mul8(input longint x, input longint y, input int n8, input int n4);
        longint ll, lh, hl, hh, s;
        ll = m_mul4(x % 16, y % 16, n4);
        lh = m_mul4(x % 16, y / 16, n4);
        hl = m_mul4(x / 16, y % 16, n4);
        hh = m_mul4(x / 16, y / 16, n4);
        s  = m_loa(lh * 16, hl * 16, 2 * n8, 16);
        s  = m_loa(s, ll, 2 * n8, 16);
        return m_loa(s, hh * 256, 2 * n8, 16);
    endfunction

    function automatic logic [31:0] model(input longint x, input longint y,
                                          input int n16, input int n8, input int n4);
        longint ll, lh, hl, hh, s;
        ll = m_mul8(x % 256, y % 256, n8, n4);
        lh = m_mul8(x % 256, y / 256, n8, n4);
        hl = m_mul8(x / 256, y % 256, n8, n4);
        hh = m_mul8(x / 256, y / 256, n8, n4);
        s  = m_loa(lh * 256, hl * 256, 2 * n16, 32);
        s  = m_loa(s, ll, 2 * n16, 32);
        s  = m_loa(s, hh * 65536, 2 * n16, 32);
        return 32'(s);
    endfunction

    // Drive an operand pair between edges, sample just after the next edge.
    task automatic step(input logic [15:0] na, input logic [15:0] nb);
        @(negedge clk);
        a = na;
        b = nb;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_ex"},  out_ex,  32'(longint'(a) * longint'(b)));
        check({tag, "_n16"}, out_n16, model(a, b, 8, 0, 0));
        check({tag, "_n4"},  out_n4,  model(a, b, 0, 0, 4));
        check({tag, "_mix"}, out_mix, model(a, b, 5, 3, 2));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b0;
        a        = '0;
        b        = '0;
        #12;
        check("rst_ex",  out_ex,  32'd0);
        check("rst_n16", out_n16, 32'd0);
        check("rst_n4",  out_n4,  32'd0);
        check("rst_mix", out_mix, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Exact-mode directed values.
        step(16'd1000, 16'd1000);
        check("ex_1000", out_ex, 32'd1000000);
        step(16'd59000, 16'd59000);
        check("ex_59000", out_ex, 32'd3481000000);
        step(16'hFFFF, 16'hFFFF);
        check("ex_max", out_ex, 32'd4294836225);

        // Approximate directed values.
        step(16'h0101, 16'h0101);
        check("n16_0101", out_n16, 32'd65793);
        check("n16_0101_model", out_n16, model(a, b, 8, 0, 0));
        step(16'h00FF, 16'h00FF);
        check("n16_00ff", out_n16, 32'd65025);
        step(16'd3, 16'd3);
        check("n4_3x3", out_n4, 32'd7);
        check("ex_3x3", out_ex, 32'd9);
        step(16'd2, 16'd3);
        check("n4_2x3", out_n4, 32'd6);

        // Throughput: one new pair per cycle.
        for (int i = 1; i <= 3; i++) begin
            step(16'(i), 16'(i));
            check($sformatf("tput_%0d", i), out_ex, 32'(i * i));
        end

        // Reset asserted between edges clears the output at once.
        step(16'd300, 16'd7);
        check("pre_rst", out_ex, 32'd2100);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_ex",  out_ex,  32'd0);
        check("mid_rst_mix", out_mix, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst", out_ex, 32'd2100);

        // Exact sweep, each pair held two cycles.
        for (int i = 0; i <= 59; i++) begin
            for (int j = 0; j <= 59; j++) begin
                step(16'(i * 1000), 16'(j * 1000));
                @(posedge clk);
                #1;
                check($sformatf("sweep_%0d_%0d", i, j), out_ex, 32'(i * j * 1000000));
            end
        end

        // Random operands against the reference model for every configuration.
        for (int i = 0; i < 400; i++) begin
            step(16'($urandom), 16'($urandom));
            check_all($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
